// File: rtl/regfile_writeback_unit_pkg.sv
// Shared widths and the buffered write-back entry type.
package regfile_writeback_unit_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Execute/memory/decode side bundle of the write-back unit.
// slave = the write-back unit, master = the surrounding pipeline.
interface regfile_writeback_unit_if
  import regfile_writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  issue_valid;
  logic                  issue_long;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rd_busy;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_a3;
  logic [XLEN-1:0]       rf_wd3;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_long, issue_rd, rs1, rs2,
    output rs1_busy, rs2_busy, rd_busy,
    output rf_we, rf_a3, rf_wd3
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_long, issue_rd, rs1, rs2,
    input  rs1_busy, rs2_busy, rd_busy,
    input  rf_we, rf_a3, rf_wd3
  );
endinterface

// File: rtl/regfile_writeback_unit_fifo.sv
// Synchronous FIFO buffering LSU results until the write port is free.
// Push when full and pop when empty are ignored. DEPTH must be a power of two.
module wb_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage: no reset needed, occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Register-file write-port driver: ALU results win the port, LSU results
// queue in a FIFO, and a busy scoreboard raises hazards for decode.
module regfile_writeback_unit
  import regfile_writeback_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  regfile_writeback_unit_if.slave wb
);
  localparam int EW = REG_ADDR_W + XLEN;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_wdata, fifo_rdata;
  logic                  alu_wr;
  logic                  we_q, we_d;
  logic                  long_q, long_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  // LSU results to x0 are acknowledged but never stored.
  assign wb.lsu_ready = !fifo_full;
  assign fifo_push    = wb.lsu_valid && !fifo_full && (wb.lsu_rd != '0);
  assign fifo_wdata   = {wb.lsu_rd, wb.lsu_data};
  assign alu_wr       = wb.alu_valid && (wb.alu_rd != '0);
  assign fifo_pop     = !alu_wr && !fifo_empty;

  wb_result_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Port arbitration: ALU first, then FIFO head; address/data hold when idle.
  always_comb begin
    we_d   = 1'b0;
    long_d = 1'b0;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    if (alu_wr) begin
      we_d  = 1'b1;
      a3_d  = wb.alu_rd;
      wd3_d = wb.alu_data;
    end else if (!fifo_empty) begin
      we_d   = 1'b1;
      long_d = 1'b1;
      a3_d   = fifo_rdata[EW-1 -: REG_ADDR_W];
      wd3_d  = fifo_rdata[XLEN-1:0];
    end
  end

  // Scoreboard next state: clear on long write capture, new issue overrides.
  always_comb begin
    busy_d = busy_q;
    if (we_q && long_q) busy_d[a3_q] = 1'b0;
    if (wb.issue_valid && wb.issue_long && (wb.issue_rd != '0))
      busy_d[wb.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      long_q <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      long_q <= long_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
    end
  end

  assign wb.rf_we  = we_q;
  assign wb.rf_a3  = a3_q;
  assign wb.rf_wd3 = wd3_q;

  // The register file has no write-through, so a value sitting on the
  // port is still a hazard for readers in decode.
  assign wb.rs1_busy = (wb.rs1 != '0) && (busy_q[wb.rs1] || (we_q && (a3_q == wb.rs1)));
  assign wb.rs2_busy = (wb.rs2 != '0) && (busy_q[wb.rs2] || (we_q && (a3_q == wb.rs2)));
  assign wb.rd_busy  = (wb.issue_rd != '0) && busy_q[wb.issue_rd];

`ifndef SYNTHESIS
  // Illegal stimulus from the pipeline; no recovery in hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(wb.issue_valid && wb.issue_long && (wb.issue_rd != '0) && busy_q[wb.issue_rd]))
        else $error("WAW: long issue to busy rd %0d", wb.issue_rd);
      assert (!(wb.alu_valid && (wb.alu_rd != '0) && busy_q[wb.alu_rd]))
        else $error("ALU result to busy rd %0d", wb.alu_rd);
      assert (!(wb.lsu_valid && !fifo_full && (wb.lsu_rd != '0) && !busy_q[wb.lsu_rd]))
        else $error("LSU result to non-busy rd %0d", wb.lsu_rd);
    end
  end
`endif
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed scenarios plus randomized legal
// traffic, checked against a queue-based model of the write-back rules.
module tb_regfile_writeback_unit;
  import regfile_writeback_unit_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_unit_if #(.XLEN(XLEN)) wb();
  regfile_writeback_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb(wb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending LSU results, busy set, and the write port.
  wb_entry_t       m_q[$];
  bit              m_busy[NUM_REGS];
  bit              m_we, m_long;
  logic [4:0]      m_a3;
  logic [XLEN-1:0] m_wd3;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
    wb.lsu_valid = 0; wb.lsu_rd = 0; wb.lsu_data = 0;
    wb.issue_valid = 0; wb.issue_long = 0; wb.issue_rd = 0;
    wb.rs1 = 0; wb.rs2 = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_we = 0; m_long = 0; m_a3 = 0; m_wd3 = 0;
  endtask

  function automatic bit m_ready();
    return m_q.size() < DEPTH;
  endfunction

  function automatic bit m_rs_busy(logic [4:0] rs);
    return (rs != 0) && (m_busy[rs] || (m_we && m_a3 == rs));
  endfunction

  // Advance the model with the inputs currently driven, then take one clock.
  task automatic tick();
    bit        push;
    wb_entry_t e;
    push = wb.lsu_valid && m_ready() && (wb.lsu_rd != 0);
    if (m_we && m_long) m_busy[m_a3] = 0;
    if (wb.issue_valid && wb.issue_long && wb.issue_rd != 0) m_busy[wb.issue_rd] = 1;
    if (wb.alu_valid && wb.alu_rd != 0) begin
      m_we = 1; m_long = 0; m_a3 = wb.alu_rd; m_wd3 = wb.alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1; m_long = 1; m_a3 = e.rd; m_wd3 = e.data;
    end else begin
      m_we = 0;
    end
    if (push) begin
      e.rd = wb.lsu_rd; e.data = wb.lsu_data;
      m_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); model_reset(); wb.rs1 = 5;
    #3;
    checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb.rf_we); end
    checks++; if (wb.rf_a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d want 0", wb.rf_a3); end
    checks++; if (wb.rf_wd3 !== '0) begin errors++; $display("FAIL reset_wd3: got %h want 0", wb.rf_wd3); end
    checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1: got %b want 0", wb.rs1_busy); end
    @(posedge clk); #1; reset = 0;
    #4;
    checks++; if (wb.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wb.lsu_ready); end
    tick();
  endtask

  task automatic test_alu_only();
    idle_inputs(); wb.alu_valid = 1; wb.alu_rd = 5; wb.alu_data = 32'h1234;
    #4; tick();
    idle_inputs(); #4;
    checks++; if (wb.rf_we !== 1'b1 || wb.rf_a3 !== 5'd5 || wb.rf_wd3 !== 32'h1234) begin
      errors++; $display("FAIL alu_write: got we=%b a3=%0d wd=%h want 1 5 1234", wb.rf_we, wb.rf_a3, wb.rf_wd3); end
    tick(); #4;
    checks++; if (wb.rf_we !== 1'b0 || wb.rf_a3 !== 5'd5) begin
      errors++; $display("FAIL alu_idle: got we=%b a3=%0d want 0 5", wb.rf_we, wb.rf_a3); end
    tick();
  endtask

  task automatic test_lsu_scoreboard();
    idle_inputs(); wb.issue_valid = 1; wb.issue_long = 1; wb.issue_rd = 7;
    #4;
    checks++; if (wb.rd_busy !== 1'b0) begin errors++; $display("FAIL sb_pre: got %b want 0", wb.rd_busy); end
    tick();
    idle_inputs(); wb.rs1 = 7; wb.issue_rd = 7;
    wb.lsu_valid = 1; wb.lsu_rd = 7; wb.lsu_data = 32'hCAFE;
    #4;
    checks++; if (wb.rs1_busy !== 1'b1 || wb.rd_busy !== 1'b1) begin
      errors++; $display("FAIL sb_set: got rs1=%b rd=%b want 1 1", wb.rs1_busy, wb.rd_busy); end
    checks++; if (wb.lsu_ready !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b want 1", wb.lsu_ready); end
    tick();
    wb.lsu_valid = 0; #4;
    checks++; if (wb.rf_we !== 1'b0 || wb.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL sb_push: got we=%b rs1=%b want 0 1", wb.rf_we, wb.rs1_busy); end
    tick(); #4;
    checks++; if (wb.rf_we !== 1'b1 || wb.rf_a3 !== 5'd7 || wb.rf_wd3 !== 32'hCAFE || wb.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL sb_write: got we=%b a3=%0d wd=%h rs1=%b want 1 7 cafe 1", wb.rf_we, wb.rf_a3, wb.rf_wd3, wb.rs1_busy); end
    tick(); #4;
    checks++; if (wb.rf_we !== 1'b0 || wb.rs1_busy !== 1'b0 || wb.rd_busy !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got we=%b rs1=%b rd=%b want 0 0 0", wb.rf_we, wb.rs1_busy, wb.rd_busy); end
    tick();
  endtask

  task automatic test_contention();
    idle_inputs(); wb.issue_valid = 1; wb.issue_long = 1; wb.issue_rd = 9;
    #4; tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); wb.alu_valid = 1; wb.alu_rd = 3; wb.alu_data = 32'hA0 + i;
      if (i == 0) begin wb.lsu_valid = 1; wb.lsu_rd = 9; wb.lsu_data = 32'h99; end
      #4;
      if (i > 0) begin
        checks++; if (wb.rf_we !== 1'b1 || wb.rf_a3 !== 5'd3 || wb.rf_wd3 !== 32'hA0 + i - 1) begin
          errors++; $display("FAIL cont_alu%0d: got a3=%0d wd=%h want 3 %h", i, wb.rf_a3, wb.rf_wd3, 32'hA0 + i - 1); end
      end
      tick();
    end
    idle_inputs(); #4;
    checks++; if (wb.rf_a3 !== 5'd3 || wb.rf_wd3 !== 32'hA2) begin
      errors++; $display("FAIL cont_alu3: got a3=%0d wd=%h want 3 a2", wb.rf_a3, wb.rf_wd3); end
    tick(); #4;
    checks++; if (wb.rf_we !== 1'b1 || wb.rf_a3 !== 5'd9 || wb.rf_wd3 !== 32'h99) begin
      errors++; $display("FAIL cont_lsu: got we=%b a3=%0d wd=%h want 1 9 99", wb.rf_we, wb.rf_a3, wb.rf_wd3); end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    int         k;
    logic [4:0] got_rd[$];
    logic [31:0] got_d[$];
    k = 0;
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); wb.issue_valid = 1; wb.issue_long = 1; wb.issue_rd = 5'(10 + i);
      #4; tick();
    end
    for (int c = 0; c < 7; c++) begin
      idle_inputs(); wb.alu_valid = 1; wb.alu_rd = 20; wb.alu_data = 32'h2000 + c;
      if (k < 5) begin wb.lsu_valid = 1; wb.lsu_rd = 5'(10 + k); wb.lsu_data = 32'h100 + k; end
      #4;
      checks++; if (wb.lsu_ready !== (k < 4)) begin
        errors++; $display("FAIL bp_ready%0d: got %b want %b", c, wb.lsu_ready, (k < 4)); end
      if (wb.lsu_valid && m_ready()) k++;
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (k < 5) begin wb.lsu_valid = 1; wb.lsu_rd = 5'(10 + k); wb.lsu_data = 32'h100 + k; end
      #4;
      if (c == 0) begin
        checks++; if (wb.lsu_ready !== 1'b0) begin errors++; $display("FAIL bp_popfull: got %b want 0", wb.lsu_ready); end
      end
      if (wb.rf_we && wb.rf_a3 != 5'd20) begin got_rd.push_back(wb.rf_a3); got_d.push_back(wb.rf_wd3); end
      if (wb.lsu_valid && m_ready()) k++;
      tick();
    end
    checks++; if (got_rd.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got_rd.size()); end
    for (int i = 0; i < got_rd.size() && i < 5; i++) begin
      checks++; if (got_rd[i] !== 5'(10 + i) || got_d[i] !== 32'h100 + i) begin
        errors++; $display("FAIL bp_order%0d: got rd=%0d d=%h want %0d %h", i, got_rd[i], got_d[i], 10 + i, 32'h100 + i); end
    end
  endtask

  task automatic test_x0();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      wb.alu_valid = 1; wb.alu_rd = 0; wb.alu_data = 32'hFFFF_FFFF;
      wb.lsu_valid = 1; wb.lsu_rd = 0; wb.lsu_data = 32'hFFFF_FFFF;
      wb.issue_valid = 1; wb.issue_long = 1; wb.issue_rd = 0; wb.rs1 = 0;
      #4;
      if (c > 0) begin
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL x0_we%0d: got %b want 0", c, wb.rf_we); end
      end
      checks++; if (wb.rs1_busy !== 1'b0 || wb.rd_busy !== 1'b0 || wb.lsu_ready !== 1'b1) begin
        errors++; $display("FAIL x0_flags%0d: got rs1=%b rd=%b rdy=%b want 0 0 1", c, wb.rs1_busy, wb.rd_busy, wb.lsu_ready); end
      tick();
    end
    idle_inputs(); #4;
    checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL x0_drain: got %b want 0", wb.rf_we); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); wb.issue_valid = 1; wb.issue_long = 1; wb.issue_rd = 5'(4 + i);
      #4; tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); wb.alu_valid = 1; wb.alu_rd = 20; wb.alu_data = 32'h300 + i;
      wb.lsu_valid = 1; wb.lsu_rd = 5'(4 + i); wb.lsu_data = 32'h400 + i;
      #4; tick();
    end
    idle_inputs(); wb.rs1 = 4;
    #2;
    checks++; if (wb.rf_we !== 1'b1 || wb.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got we=%b rs1=%b want 1 1", wb.rf_we, wb.rs1_busy); end
    reset = 1; #1;
    checks++; if (wb.rf_we !== 1'b0 || wb.rs1_busy !== 1'b0) begin
      errors++; $display("FAIL rm_async: got we=%b rs1=%b want 0 0", wb.rf_we, wb.rs1_busy); end
    @(posedge clk); #1; reset = 0; model_reset();
    for (int c = 0; c < 6; c++) begin
      wb.rs1 = 5'(4 + c % 3); #4;
      checks++; if (wb.rf_we !== 1'b0 || wb.lsu_ready !== 1'b1 || wb.rs1_busy !== 1'b0) begin
        errors++; $display("FAIL rm_after%0d: got we=%b rdy=%b rs1=%b want 0 1 0", c, wb.rf_we, wb.lsu_ready, wb.rs1_busy); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0] outl[$];
    logic [4:0] r;
    bit         ok;
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      if ($urandom_range(1, 0) == 1) begin
        ok = 0;
        for (int t = 0; t < 64 && !ok; t++) begin r = 5'($urandom); ok = !m_busy[r]; end
        if (ok) begin wb.alu_valid = 1; wb.alu_rd = r; wb.alu_data = $urandom; end
      end
      if ($urandom_range(2, 0) == 0) begin
        wb.issue_long = 1'($urandom);
        ok = 0;
        for (int t = 0; t < 64 && !ok; t++) begin
          r = 5'($urandom);
          ok = !wb.issue_long || (!m_busy[r] && !(wb.alu_valid && wb.alu_rd == r));
        end
        if (ok) begin wb.issue_valid = 1; wb.issue_rd = r; end else wb.issue_long = 0;
      end else begin
        wb.issue_rd = 5'($urandom);
      end
      if (outl.size() > 0 && $urandom_range(1, 0) == 1) begin
        wb.lsu_valid = 1; wb.lsu_rd = outl[$urandom_range(outl.size() - 1, 0)]; wb.lsu_data = $urandom;
      end else if ($urandom_range(7, 0) == 0) begin
        wb.lsu_valid = 1; wb.lsu_rd = 0; wb.lsu_data = $urandom;
      end
      wb.rs1 = 5'($urandom); wb.rs2 = 5'($urandom);
      #4;
      checks++; if (wb.lsu_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, wb.lsu_ready, m_ready()); end
      checks++; if (wb.rf_we !== m_we || wb.rf_a3 !== m_a3 || wb.rf_wd3 !== m_wd3) begin
        errors++; $display("FAIL rnd_port@%0d: got %b %0d %h want %b %0d %h", c, wb.rf_we, wb.rf_a3, wb.rf_wd3, m_we, m_a3, m_wd3); end
      checks++; if (wb.rs1_busy !== m_rs_busy(wb.rs1) || wb.rs2_busy !== m_rs_busy(wb.rs2)) begin
        errors++; $display("FAIL rnd_rs@%0d: got %b %b want %b %b", c, wb.rs1_busy, wb.rs2_busy, m_rs_busy(wb.rs1), m_rs_busy(wb.rs2)); end
      checks++; if (wb.rd_busy !== (wb.issue_rd != 0 && m_busy[wb.issue_rd])) begin
        errors++; $display("FAIL rnd_rd@%0d: got %b want %b", c, wb.rd_busy, (wb.issue_rd != 0 && m_busy[wb.issue_rd])); end
      if (wb.lsu_valid && wb.lsu_rd != 0 && m_ready())
        foreach (outl[i]) if (outl[i] == wb.lsu_rd) begin outl.delete(i); break; end
      if (wb.issue_valid && wb.issue_long && wb.issue_rd != 0) outl.push_back(wb.issue_rd);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_lsu_scoreboard();
    test_contention();
    test_backpressure();
    test_x0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
Writer side of the register-file write port (a3/wd3/we). Merges single-cycle ALU results and long-latency LSU results (valid/ready) into the one write port. Buffers LSU results in a small FIFO. Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards. Sits between execute/memory stages and the register file.

Parameters:
XLEN, 32, data width of results and write port
FIFO_DEPTH, 4, LSU result buffer entries; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present this cycle; always accepted, no backpressure
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU result offered
lsu_ready  output  1  FIFO can accept; equals !full, from registered count only
lsu_rd  input  5  LSU destination register
lsu_data  input  XLEN  LSU result
issue_valid  input  1  decode issues an instruction this cycle
issue_long  input  1  issued instruction writes back via the LSU path
issue_rd  input  5  destination of issued instruction
rs1, rs2  input  5 each  source registers of the instruction in decode
rs1_busy, rs2_busy, rd_busy  output  1 each  combinational hazard flags for rs1/rs2/issue_rd
rf_we  output  1  register-file write enable
rf_a3  output  5  register-file write address
rf_wd3  output  XLEN  register-file write data

Behaviour:
- Reset (async, active-high): rf_we=0, rf_a3=0, rf_wd3=0, busy[31:0]=0, FIFO empty (lsu_ready=1 after reset). In-flight results are discarded mid-operation.
- LSU accept: handshake when lsu_valid && lsu_ready. Push {rd,data} into the FIFO unless lsu_rd==0; rd 0 is accepted and dropped, and lsu_ready is unaffected.
- Write-port arbitration each cycle, fixed priority ALU > FIFO head:
  - alu_valid && alu_rd!=0: load rf_* with the ALU result and set the src_long flag to 0.
  - Otherwise, if the FIFO is non-empty: pop the head, load rf_* with it, set src_long=1.
  - Otherwise: rf_we=0. rf_a3 and rf_wd3 hold their last value.
  - alu_valid && alu_rd==0 writes nothing and does not block the FIFO pop.
- Latency: result accepted at edge N appears on rf_* after edge N. The register file captures it at edge N+1. The ALU-to-rf_* latency is 1 cycle. The LSU path is at least 2 cycles (push, then pop).
- Push and pop in the same cycle are allowed. When the FIFO is full, a pop does not raise lsu_ready in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. The count register is FIFO_DEPTH+1 states wide.
- Scoreboard:
  - Set busy[issue_rd] on issue_valid && issue_long && issue_rd!=0.
  - Clear busy[rf_a3] at the edge where rf_we && src_long (the register file captures the data at the same edge).
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is never set.
- Hazard flags:
  - rsX_busy = rsX!=0 && (busy[rsX] || (rf_we && rf_a3==rsX)). The second term covers data that is not yet in the register file, which has no write-through.
  - rd_busy = issue_rd!=0 && busy[issue_rd].
  - Decode must stall on any flag.
- Illegal stimulus, flagged by a simulation-only assertion with no RTL recovery:
  - issue_long to a busy rd (WAW).
  - alu_valid to a busy rd.
  - LSU result for an rd that is not busy (rd!=0).

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NUM_REGS=32, and a wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_result_fifo (synchronous FIFO with parameterised depth, push/pop/full/empty, async reset).
- The scoreboard and arbiter stay in the top module.

Test Plan:
- ALU-only write: alu_valid, rd=5, data=0x1234 at cycle 0 -> rf_we=1, rf_a3=5, rf_wd3=0x1234 in cycle 1; rf_we=0 in cycle 2.
- LSU path with scoreboard: issue_long rd=7 -> rs1=7 gives rs1_busy=1. LSU returns rd=7, data=0xCAFE -> rf_* shows it 2 cycles later; busy clears after that write edge; rs1_busy=0 on the next cycle.
- Contention: alu_valid (rd=3) held for 3 cycles while LSU pushes rd=9 -> ALU writes in cycles 1-3; rd=9 is written in cycle 4.
- Backpressure: FIFO_DEPTH=4, ALU busy continuously, 5 LSU results offered -> lsu_ready=0 after the 4th push. Once ALU idles, results drain in FIFO order with no loss or duplication.
- x0 handling: alu rd=0 and lsu rd=0 (data 0xFFFF_FFFF) -> rf_we never asserted for rd 0; issue_long rd=0 leaves busy[0]=0 and rs1_busy=0 for rs1=0.
- Reset mid-operation: 3 FIFO entries pending and busy[4]=1, assert reset -> rf_we=0 immediately; after release lsu_ready=1, busy=0, and no stale write appears.
